dmem_responder: RTL and testbench

//   Memory-side responder for the pipeline's MEM-stage data accesses (load/store word).
//   - Accepts one request at a time from the MEM-stage initiator.
//   - Models LATENCY wait states and answers with a single-cycle response pulse.
//   - Drives a combinational stall that freezes the pipeline while an access is in flight.
//   - Sits beside Stage3/Stage4: the request comes from the MEM-stage ALU result and store data;
//     the read data goes to the MEM/WB register.
//

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for MEM-stage load/store word accesses.
// Takes one request at a time, inserts LATENCY wait states, then issues a
// one-cycle response pulse. While an access is in flight it raises a
// combinational stall that freezes the front of the pipeline.
//
// Handshake: a request is accepted on a rising edge when req_valid and
// req_ready are both high. req_ready is high only in IDLE. rsp_valid is high
// for exactly one cycle per accepted request and carries no back-pressure.
// Request inputs are ignored outside IDLE, so an access always completes
// once it has been accepted.
module dmem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        stall,
  output logic [1:0]  dbgState
);

  localparam logic [1:0] stIdle = 2'd0;
  localparam logic [1:0] stWait = 2'd1;
  localparam logic [1:0] stResp = 2'd2;

  // Counter preload on acceptance. LATENCY==0 never uses WAIT, so the value is moot.
  localparam logic [3:0] waitInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]    state;
  logic [1:0]    nextState;
  logic [3:0]    counter;
  logic [3:0]    nextCounter;

  logic          capWrite;
  logic [AW-1:0] capAddr;
  logic [31:0]   capWdata;

  logic          accept;
  logic          enterResp;
  logic          commitWrite;
  logic [AW-1:0] commitAddr;
  logic [31:0]   commitWdata;

  logic [31:0]   mem [0:(1 << AW) - 1];

  // Address bits above AW-1 alias; they are deliberately not decoded.
  logic          unusedAddrHi;
  assign unusedAddrHi = ^req_addr[15:AW];

  assign accept    = (state == stIdle) && req_valid;
  assign req_ready = (state == stIdle);
  assign rsp_valid = (state == stResp);
  assign stall     = accept || (state == stWait);
  assign dbgState  = state;

  // The commit edge is the edge entering RESP. With zero latency that is the
  // acceptance edge itself, so the live inputs are used instead of the capture.
  assign enterResp   = (accept && (LATENCY == 0)) ||
                       ((state == stWait) && (counter == 4'd0));
  assign commitWrite = (state == stIdle) ? req_write           : capWrite;
  assign commitAddr  = (state == stIdle) ? req_addr[AW-1:0]    : capAddr;
  assign commitWdata = (state == stIdle) ? req_wdata           : capWdata;

  // Next-state and wait-counter decode.
  always_comb begin
    nextState   = state;
    nextCounter = counter;
    case (state)
      stIdle: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            nextState = stResp;
          end else begin
            nextState   = stWait;
            nextCounter = waitInit;
          end
        end
      end
      stWait: begin
        if (counter == 4'd0) begin
          nextState = stResp;
        end else begin
          nextCounter = counter - 4'd1;
        end
      end
      stResp: begin
        nextState = stIdle;
      end
      default: begin
        nextState   = stIdle;
        nextCounter = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= stIdle;
      counter <= 4'd0;
    end else begin
      state   <= nextState;
      counter <= nextCounter;
    end
  end

  // Capture the request on acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      capWrite <= 1'b0;
      capAddr  <= '0;
      capWdata <= 32'd0;
    end else if (accept) begin
      capWrite <= req_write;
      capAddr  <= req_addr[AW-1:0];
      capWdata <= req_wdata;
    end
  end

  // Response data: store echoes the written word, load returns the stored word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_rdata <= 32'd0;
    end else if (enterResp) begin
      rsp_rdata <= commitWrite ? commitWdata : mem[commitAddr];
    end
  end

  // Storage array, not reset; a store lands on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (enterResp && commitWrite) begin
      mem[commitAddr] <= commitWdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances cover LATENCY 2, 0 and 3.
module tb_dmem_responder;

  localparam logic [1:0] stIdle = 2'd0;
  localparam logic [1:0] stWait = 2'd1;
  localparam logic [1:0] stResp = 2'd2;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  // Instance A: LATENCY=2
  logic        vA, wA, readyA, rspA, stallA;
  logic [15:0] aA;
  logic [31:0] dA, rdA;
  logic [1:0]  stA;

  // Instance B: LATENCY=0
  logic        vB, wB, readyB, rspB, stallB;
  logic [15:0] aB;
  logic [31:0] dB, rdB;
  logic [1:0]  stB;

  // Instance C: LATENCY=3
  logic        vC, wC, readyC, rspC, stallC;
  logic [15:0] aC;
  logic [31:0] dC, rdC;
  logic [1:0]  stC;

  dmem_responder #(.AW(10), .LATENCY(2)) dutA (
    .clk(clk), .rst(rst), .req_valid(vA), .req_write(wA), .req_addr(aA),
    .req_wdata(dA), .req_ready(readyA), .rsp_valid(rspA), .rsp_rdata(rdA),
    .stall(stallA), .dbgState(stA)
  );

  dmem_responder #(.AW(10), .LATENCY(0)) dutB (
    .clk(clk), .rst(rst), .req_valid(vB), .req_write(wB), .req_addr(aB),
    .req_wdata(dB), .req_ready(readyB), .rsp_valid(rspB), .rsp_rdata(rdB),
    .stall(stallB), .dbgState(stB)
  );

  dmem_responder #(.AW(10), .LATENCY(3)) dutC (
    .clk(clk), .rst(rst), .req_valid(vC), .req_write(wC), .req_addr(aC),
    .req_wdata(dC), .req_ready(readyC), .rsp_valid(rspC), .rsp_rdata(rdC),
    .stall(stallC), .dbgState(stC)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to just after the next rising edge; inputs are driven here.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on instance A with full cycle-by-cycle timing checks.
  task automatic accessA(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [31:0] expRd, input logic perturb);
    nextCycle();
    vA = 1'b1; wA = wr; aA = addr; dA = wd;
    #1;
    check({tag, ".T.ready"}, 32'(readyA), 32'd1);
    check({tag, ".T.stall"}, 32'(stallA), 32'd1);
    check({tag, ".T.rsp"},   32'(rspA),   32'd0);
    nextCycle();
    if (perturb) begin
      vA = 1'b1; wA = 1'b1; aA = 16'h0009; dA = 32'hFFFF_FFFF;
    end else begin
      vA = 1'b0;
    end
    #1;
    check({tag, ".T1.state"}, 32'(stA),    32'(stWait));
    check({tag, ".T1.ready"}, 32'(readyA), 32'd0);
    check({tag, ".T1.stall"}, 32'(stallA), 32'd1);
    check({tag, ".T1.rsp"},   32'(rspA),   32'd0);
    nextCycle();
    #1;
    check({tag, ".T2.stall"}, 32'(stallA), 32'd1);
    check({tag, ".T2.rsp"},   32'(rspA),   32'd0);
    nextCycle();
    vA = 1'b0;
    #1;
    check({tag, ".T3.rsp"},   32'(rspA),   32'd1);
    check({tag, ".T3.state"}, 32'(stA),    32'(stResp));
    check({tag, ".T3.stall"}, 32'(stallA), 32'd0);
    check({tag, ".T3.ready"}, 32'(readyA), 32'd0);
    check({tag, ".T3.rdata"}, rdA,         expRd);
    nextCycle();
    #1;
    check({tag, ".T4.rsp"},   32'(rspA),   32'd0);
    check({tag, ".T4.ready"}, 32'(readyA), 32'd1);
    check({tag, ".T4.hold"},  rdA,         expRd);
  endtask

  // One access on instance B (zero latency).
  task automatic accessB(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [31:0] expRd);
    nextCycle();
    vB = 1'b1; wB = wr; aB = addr; dB = wd;
    #1;
    check({tag, ".T.ready"}, 32'(readyB), 32'd1);
    check({tag, ".T.stall"}, 32'(stallB), 32'd1);
    check({tag, ".T.rsp"},   32'(rspB),   32'd0);
    nextCycle();
    vB = 1'b0;
    #1;
    check({tag, ".T1.rsp"},   32'(rspB),   32'd1);
    check({tag, ".T1.ready"}, 32'(readyB), 32'd0);
    check({tag, ".T1.stall"}, 32'(stallB), 32'd0);
    check({tag, ".T1.rdata"}, rdB,         expRd);
    nextCycle();
    #1;
    check({tag, ".T2.rsp"},   32'(rspB),   32'd0);
    check({tag, ".T2.ready"}, 32'(readyB), 32'd1);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    vA = 1'b0; wA = 1'b0; aA = 16'h0; dA = 32'h0;
    vB = 1'b0; wB = 1'b0; aB = 16'h0; dB = 32'h0;
    vC = 1'b0; wC = 1'b0; aC = 16'h0; dC = 32'h0;

    // Reset state
    nextCycle();
    nextCycle();
    check("rst.stateA", 32'(stA),    32'(stIdle));
    check("rst.readyA", 32'(readyA), 32'd1);
    check("rst.rspA",   32'(rspA),   32'd0);
    check("rst.rdA",    rdA,         32'h0);
    check("rst.stallA", 32'(stallA), 32'd0);
    check("rst.rspB",   32'(rspB),   32'd0);
    check("rst.rspC",   32'(rspC),   32'd0);
    rst = 1'b1;

    // Reset mid-WAIT drops the store and suppresses the response
    accessA("pre5", 1'b1, 16'h0005, 32'h1111_1111, 32'h1111_1111, 1'b0);
    nextCycle();
    vA = 1'b1; wA = 1'b1; aA = 16'h0005; dA = 32'hDEAD_BEEF;
    #1;
    check("abort.stall", 32'(stallA), 32'd1);
    nextCycle();
    vA = 1'b0;
    #1;
    check("abort.wait", 32'(stA), 32'(stWait));
    rst = 1'b0;
    #1;
    check("abort.state", 32'(stA),    32'(stIdle));
    check("abort.rsp",   32'(rspA),   32'd0);
    check("abort.rdata", rdA,         32'h0);
    check("abort.ready", 32'(readyA), 32'd1);
    nextCycle();
    nextCycle();
    check("abort.norsp", 32'(rspA), 32'd0);
    rst = 1'b1;
    accessA("ld5", 1'b0, 16'h0005, 32'h0, 32'h1111_1111, 1'b0);

    // Store then load at LATENCY=2
    accessA("st3", 1'b1, 16'h0003, 32'h1234_5678, 32'h1234_5678, 1'b0);
    accessA("ld3", 1'b0, 16'h0003, 32'h0,         32'h1234_5678, 1'b0);

    // Aliasing above bit AW-1
    accessA("st401", 1'b1, 16'h0401, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
    accessA("ld001", 1'b0, 16'h0001, 32'h0,         32'hA5A5_A5A5, 1'b0);

    // Inputs changing during WAIT are ignored
    accessA("st9",   1'b1, 16'h0009, 32'h0000_0909, 32'h0000_0909, 1'b0);
    accessA("st2p",  1'b1, 16'h0002, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b1);
    accessA("ld2",   1'b0, 16'h0002, 32'h0,         32'h0BAD_F00D, 1'b0);
    accessA("ld9",   1'b0, 16'h0009, 32'h0,         32'h0000_0909, 1'b0);

    // Zero latency
    accessB("b.st7", 1'b1, 16'h0007, 32'h7777_0007, 32'h7777_0007);
    accessB("b.ld7", 1'b0, 16'h0007, 32'h0,         32'h7777_0007);

    // req_valid held high at LATENCY=3: one acceptance every 5 cycles
    nextCycle();
    vC = 1'b1; wC = 1'b1; aC = 16'h0010;
    for (int i = 0; i < 15; i++) begin
      dC = 32'hC0C0_0000 + 32'(i);
      #1;
      check($sformatf("c.rsp%0d", i),   32'(rspC),   ((i % 5) == 4) ? 32'd1 : 32'd0);
      check($sformatf("c.ready%0d", i), 32'(readyC), ((i % 5) == 0) ? 32'd1 : 32'd0);
      check($sformatf("c.stall%0d", i), 32'(stallC), ((i % 5) != 4) ? 32'd1 : 32'd0);
      if ((i % 5) == 4) begin
        check($sformatf("c.rdata%0d", i), rdC, 32'hC0C0_0000 + 32'(i - 4));
      end
      nextCycle();
    end
    vC = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
